flap_position_driver: RTL

- Command-side initiator for the flap indicator. It accepts a target position and emits single-cycle change_position_re pulses until the indicator's display bus matches the target.
- Flaps only advance forward, so the driver always steps forward, wrapping from NUM_POSITIONS-1 to 0.
- It also forwards one-shot mode-toggle requests as change_mode_re pulses.
- It sits between the system sequencer and flap_indicator_3 and closes the loop via the display bus.

---
 rtl/flap_pkg.sv | 23 ++
 rtl/flap_settle_timer.sv | 53 +++++
 rtl/flap_position_driver.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/flap_pkg.sv
// -----------------------------------------------------------------------------
// flap_pkg
// Shared definitions for the flap indicator command side.
//   - state_e               : driver FSM states
//   - DEFAULT_NUM_POSITIONS : default number of flap positions on the drum
//   - DISPLAY_WIDTH         : width of the display encoding, shared with
//                             flap_indicator_3
// -----------------------------------------------------------------------------
package flap_pkg;

    localparam int DEFAULT_NUM_POSITIONS = 256;
    localparam int DISPLAY_WIDTH         = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_PULSE,
        ST_SETTLE,
        ST_DONE,
        ST_FAULT
    } state_e;

endpackage : flap_pkg

// File: rtl/flap_settle_timer.sv
// -----------------------------------------------------------------------------
// flap_settle_timer
// Loadable down-counter with a zero flag. The driver loads it while leaving
// PULSE and watches is_zero in SETTLE to know when the indicator has had
// time to move.
// Ports:
//   clk        in   system clock
//   sync_reset in   synchronous active-high reset, clears the count
//   load       in   load load_value this cycle (has priority over enable)
//   load_value in   value to load
//   enable     in   decrement while non-zero
//   is_zero    out  count is zero
// -----------------------------------------------------------------------------
module flap_settle_timer
    import flap_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             is_zero
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign is_zero = (count_q == '0);

endmodule : flap_settle_timer

// File: rtl/flap_position_driver.sv
// -----------------------------------------------------------------------------
// flap_position_driver
// Command-side initiator for the flap indicator. Accepts a target position and
// issues single-cycle change_position_re pulses, always stepping forward, until
// display_in matches the target. Also forwards one-shot mode toggles as
// change_mode_re pulses.
// Ports:
//   clk, sync_reset         clock and synchronous active-high reset
//   target_valid/target     command handshake in, target_ready out
//   mode_req                request one mode toggle
//   display_in              current position reported by the indicator
//   change_position_re      one-cycle advance pulse to the indicator
//   change_mode_re          one-cycle mode-toggle pulse to the indicator
//   busy                    command in progress (CHECK / PULSE / SETTLE)
//   done                    one-cycle pulse when display_in reached target
//   fault                   held while target unreachable or out of range
//   steps                   pulses issued for the current/last command
// -----------------------------------------------------------------------------
module flap_position_driver
    import flap_pkg::*;
#(
    parameter int POS_WIDTH     = DISPLAY_WIDTH,
    parameter int NUM_POSITIONS = DEFAULT_NUM_POSITIONS,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 sync_reset,
    input  logic                 target_valid,
    input  logic [POS_WIDTH-1:0] target,
    output logic                 target_ready,
    input  logic                 mode_req,
    input  logic [POS_WIDTH-1:0] display_in,
    output logic                 change_position_re,
    output logic                 change_mode_re,
    output logic                 busy,
    output logic                 done,
    output logic                 fault,
    output logic [POS_WIDTH:0]   steps
);

    // The timer holds SETTLE_CYCLES-1: SETTLE spends one cycle per count
    // value down to and including zero, i.e. exactly SETTLE_CYCLES cycles.
    localparam int                    SETTLE_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0]   SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    // One bit wider than the position bus so NUM_POSITIONS = 2^POS_WIDTH fits.
    localparam logic [POS_WIDTH:0]    STEP_LIMIT  = (POS_WIDTH + 1)'(NUM_POSITIONS);

    state_e                 state_d;
    state_e                 state_q;
    logic [POS_WIDTH-1:0]   target_d;
    logic [POS_WIDTH-1:0]   target_q;
    logic [POS_WIDTH:0]     steps_d;
    logic [POS_WIDTH:0]     steps_q;
    logic                   done_d;
    logic                   done_q;
    logic                   mode_pulse_d;
    logic                   mode_pulse_q;

    logic                   accept;
    logic                   target_in_range;
    logic                   settle_load;
    logic                   settle_zero;

    assign accept          = target_valid && target_ready;
    assign target_in_range = ({1'b0, target} < STEP_LIMIT);

    flap_settle_timer #(
        .WIDTH (SETTLE_W)
    ) u_settle_timer (
        .clk        (clk),
        .sync_reset (sync_reset),
        .load       (settle_load),
        .load_value (SETTLE_LOAD),
        .enable     (state_q == ST_SETTLE),
        .is_zero    (settle_zero)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q      <= ST_IDLE;
            target_q     <= '0;
            steps_q      <= '0;
            done_q       <= 1'b0;
            mode_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            steps_q      <= steps_d;
            done_q       <= done_d;
            mode_pulse_q <= mode_pulse_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        steps_d     = steps_q;
        settle_load = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                if (accept) begin
                    target_d = target;
                    steps_d  = '0;
                    state_d  = target_in_range ? ST_CHECK : ST_FAULT;
                end
            end
            ST_CHECK: begin
                // Match wins over the step limit so the last allowed pulse
                // can still complete the command.
                if (display_in == target_q) begin
                    state_d = ST_DONE;
                end else if (steps_q == STEP_LIMIT) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                steps_d     = steps_q + 1'b1;
                settle_load = 1'b1;
                state_d     = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_zero) begin
                    state_d = ST_CHECK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // done marks only the CHECK->DONE transition, so it lasts one cycle
        // even though DONE is held until the next command.
        done_d = (state_q == ST_CHECK) && (state_d == ST_DONE);

        // Blocking on mode_pulse_q makes a held mode_req toggle every other
        // cycle. Mode requests are only taken when the driver is idle, so
        // they can never coincide with a position pulse.
        mode_pulse_d = mode_req && target_ready && !target_valid && !mode_pulse_q;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        target_ready       = 1'b0;
        busy               = 1'b0;
        change_position_re = 1'b0;
        fault              = 1'b0;

        unique case (state_q)
            ST_IDLE:   target_ready = 1'b1;
            ST_CHECK:  busy         = 1'b1;
            ST_PULSE: begin
                busy               = 1'b1;
                change_position_re = 1'b1;
            end
            ST_SETTLE: busy         = 1'b1;
            ST_DONE:   target_ready = 1'b1;
            ST_FAULT: begin
                target_ready = 1'b1;
                fault        = 1'b1;
            end
            default:   target_ready = 1'b0;
        endcase
    end

    assign done           = done_q;
    assign change_mode_re = mode_pulse_q;
    assign steps          = steps_q;

endmodule : flap_position_driver
